// File: rtl/rover_pkg.sv
// Shared definitions for the rover search scheduler: state encoding and
// the per-state brake/drive output decode.
package rover_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned MINES_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ADVANCE   = 3'd1,
        ST_SWEEP     = 3'd2,
        ST_MINE_HOLD = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_FAULT     = 3'd5
    } rover_state_e;

    typedef struct packed {
        logic drive_en;
        logic drive_brake;
        logic carriage_brake;
        logic fault;
    } rover_out_t;

    // Brakes default on; anything unrecognised decodes as a safe stop.
    function automatic rover_out_t decode_outputs(input rover_state_e s);
        rover_out_t o;
        o = '{drive_en: 1'b0, drive_brake: 1'b1, carriage_brake: 1'b1, fault: 1'b0};
        case (s)
            ST_ADVANCE: begin
                o.drive_en    = 1'b1;
                o.drive_brake = 1'b0;
            end
            ST_SWEEP, ST_MINE_HOLD, ST_SETTLE: o.carriage_brake = 1'b0;
            ST_FAULT:   o.fault = 1'b1;
            default:    ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rover_dwell_timer.sv
// Loadable down-counter that parks at zero; done is high while it reads zero.
module rover_dwell_timer #(
    parameter int unsigned CNT_W = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rover_sequencer.sv
// Rover search scheduler: alternates drive steps with carriage sweeps,
// holds the drive while a mine is flagged, and faults on timeouts.
module rover_sequencer
    import rover_pkg::*;
#(
    parameter int unsigned STEP_CYCLES   = 50_000_000,
    parameter int unsigned SETTLE_CYCLES = 10_000_000,
    parameter int unsigned SWEEP_TIMEOUT = 300_000_000,
    parameter int unsigned MINE_TIMEOUT  = 500_000_000,
    parameter int unsigned CNT_W         = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mine,
    input  logic               end_a,
    input  logic               end_b,
    output logic               drive_en,
    output logic               drive_brake,
    output logic               carriage_brake,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [MINES_W-1:0] mines_cleared
);

    rover_state_e     state_q;
    rover_state_e     state_nxt;
    logic             end_a_q;
    logic             end_b_q;
    logic             end_edge_c;
    logic             timer_done;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             clear_done_c;
    rover_out_t       out_nxt;

    assign end_edge_c = (end_a & ~end_a_q) | (end_b & ~end_b_q);

    rover_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Next state in priority order: enable, then mine, then timer/end edge.
    always_comb begin
        state_nxt    = state_q;
        clear_done_c = 1'b0;
        timer_val    = '0;
        timer_load   = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_nxt = ST_ADVANCE;
                ST_ADVANCE: begin
                    if (mine)            state_nxt = ST_MINE_HOLD;
                    else if (timer_done) state_nxt = ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (mine)            state_nxt = ST_MINE_HOLD;
                    else if (end_edge_c) state_nxt = ST_ADVANCE;
                    else if (timer_done) state_nxt = ST_FAULT;
                end
                ST_MINE_HOLD: begin
                    if (!mine)           state_nxt = ST_SETTLE;
                    else if (timer_done) state_nxt = ST_FAULT;
                end
                ST_SETTLE: begin
                    if (mine) begin
                        state_nxt = ST_MINE_HOLD;
                    end else if (timer_done) begin
                        state_nxt    = ST_ADVANCE;
                        clear_done_c = 1'b1;
                    end
                end
                ST_FAULT:     state_nxt = ST_FAULT;
                default:      state_nxt = ST_IDLE;
            endcase
        end

        // Every state change reloads the dwell for the state being entered.
        timer_load = (state_nxt != state_q);
        case (state_nxt)
            ST_ADVANCE:   timer_val = CNT_W'(STEP_CYCLES - 1);
            ST_SWEEP:     timer_val = CNT_W'(SWEEP_TIMEOUT - 1);
            ST_MINE_HOLD: timer_val = CNT_W'(MINE_TIMEOUT - 1);
            ST_SETTLE:    timer_val = CNT_W'(SETTLE_CYCLES - 1);
            default:      timer_val = '0;
        endcase

        out_nxt = decode_outputs(state_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            end_a_q        <= 1'b0;
            end_b_q        <= 1'b0;
            drive_en       <= 1'b0;
            drive_brake    <= 1'b1;
            carriage_brake <= 1'b1;
            fault          <= 1'b0;
            mines_cleared  <= '0;
        end else begin
            state_q        <= state_nxt;
            end_a_q        <= end_a;
            end_b_q        <= end_b;
            drive_en       <= out_nxt.drive_en;
            drive_brake    <= out_nxt.drive_brake;
            carriage_brake <= out_nxt.carriage_brake;
            fault          <= out_nxt.fault;
            if (clear_done_c && (mines_cleared != {MINES_W{1'b1}})) begin
                mines_cleared <= mines_cleared + MINES_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_rover_sequencer.sv
// Scoreboard bench for rover_sequencer: a cycle model queues the expected
// outputs for every driven cycle; directed checks cover the key scenarios.
module tb_rover_sequencer;

    localparam int unsigned STEP   = 8;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned SWT    = 20;
    localparam int unsigned MT     = 30;

    logic       clk = 1'b0;
    logic       rst_n, enable, mine, end_a, end_b;
    logic       drive_en, drive_brake, carriage_brake, fault;
    logic [2:0] state;
    logic [7:0] mines_cleared;

    int total = 0;
    int bad   = 0;

    logic [14:0] sb_q[$];

    int   m_st, m_age, m_mines;
    logic m_ea, m_eb;

    always #5 clk = ~clk;

    rover_sequencer #(
        .STEP_CYCLES   (STEP),
        .SETTLE_CYCLES (SETTLE),
        .SWEEP_TIMEOUT (SWT),
        .MINE_TIMEOUT  (MT),
        .CNT_W         (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .mine           (mine),
        .end_a          (end_a),
        .end_b          (end_b),
        .drive_en       (drive_en),
        .drive_brake    (drive_brake),
        .carriage_brake (carriage_brake),
        .fault          (fault),
        .state          (state),
        .mines_cleared  (mines_cleared)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] model_vec();
        logic de, db, cb, f;
        de = (m_st == 1);
        db = !de;
        cb = !(m_st == 2 || m_st == 3 || m_st == 4);
        f  = (m_st == 5);
        return {3'(m_st), de, db, cb, f, 8'(m_mines)};
    endfunction

    // Reference behaviour, tracking time spent in the current state.
    task automatic model_step();
        int   nst;
        logic edge_seen;
        if (!rst_n) begin
            m_st = 0; m_age = 0; m_mines = 0; m_ea = 1'b0; m_eb = 1'b0;
            return;
        end
        edge_seen = (end_a && !m_ea) || (end_b && !m_eb);
        nst = m_st;
        if (!enable) nst = 0;
        else begin
            case (m_st)
                0: nst = 1;
                1: if (mine) nst = 3; else if (m_age == STEP - 1) nst = 2;
                2: if (mine) nst = 3; else if (edge_seen) nst = 1;
                   else if (m_age == SWT - 1) nst = 5;
                3: if (!mine) nst = 4; else if (m_age == MT - 1) nst = 5;
                4: if (mine) nst = 3;
                   else if (m_age == SETTLE - 1) begin
                       nst = 1;
                       if (m_mines < 255) m_mines++;
                   end
                default: nst = m_st;
            endcase
        end
        m_age = (nst != m_st) ? 0 : m_age + 1;
        m_st  = nst;
        m_ea  = end_a;
        m_eb  = end_b;
    endtask

    task automatic tick();
        logic [14:0] exp;
        model_step();
        sb_q.push_back(model_vec());
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check("cyc", {state, drive_en, drive_brake, carriage_brake, fault, mines_cleared}, 32'(exp));
        check("excl", 32'(drive_en & drive_brake), 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; enable = 1'b0; mine = 1'b0; end_a = 1'b0; end_b = 1'b0;
        m_st = 0; m_age = 0; m_mines = 0; m_ea = 1'b0; m_eb = 1'b0;
        ticks(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({drive_en, drive_brake, carriage_brake, fault}), 32'b0110);
        check("rst_mines", 32'(mines_cleared), 32'd0);
        rst_n = 1'b1;
        tick();

        // Advance for exactly STEP cycles, then sweep
        enable = 1'b1;
        tick();
        check("adv_entry", 32'(state), 32'd1);
        guard = 0;
        while (drive_en && guard < 20) begin
            tick();
            guard++;
        end
        check("step_len", 32'(guard), 32'(STEP));
        check("sweep_state", 32'(state), 32'd2);
        check("sweep_cbrk", 32'(carriage_brake), 32'd0);

        // End edge returns to advance; held switch then times out the sweep
        ticks(3);
        end_b = 1'b1;
        tick();
        check("endb_edge", 32'(state), 32'd1);
        ticks(STEP);
        check("sweep2", 32'(state), 32'd2);
        ticks(SWT - 1);
        check("sweep_wait", 32'(state), 32'd2);
        tick();
        check("sweep_to", 32'(state), 32'd5);
        check("sweep_to_flt", 32'(fault), 32'd1);
        end_b = 1'b0;
        enable = 1'b0;
        tick();
        check("flt_clear", 32'({state, fault}), 32'd0);

        // Mine at advance cycle 3, then a full settle
        enable = 1'b1;
        tick();
        ticks(3);
        mine = 1'b1;
        tick();
        check("mine_hold", 32'({state, drive_en, drive_brake}), 32'b011_0_1);
        mine = 1'b0;
        tick();
        check("settle", 32'(state), 32'd4);
        ticks(SETTLE - 1);
        check("settle_wait", 32'(state), 32'd4);
        tick();
        check("settle_done", 32'(state), 32'd1);
        check("cleared1", 32'(mines_cleared), 32'd1);

        // Mine and end edge together in sweep: mine wins
        ticks(STEP);
        check("sweep3", 32'(state), 32'd2);
        ticks(2);
        mine = 1'b1;
        end_a = 1'b1;
        tick();
        check("mine_vs_edge", 32'(state), 32'd3);
        end_a = 1'b0;

        // Mine reasserted mid-settle restarts the whole settle
        mine = 1'b0;
        tick();
        ticks(2);
        mine = 1'b1;
        tick();
        check("reassert", 32'(state), 32'd3);
        mine = 1'b0;
        tick();
        ticks(SETTLE - 1);
        check("resettle", 32'(state), 32'd4);
        tick();
        check("resettle_done", 32'(state), 32'd1);
        check("cleared2", 32'(mines_cleared), 32'd2);

        // Mine held too long faults; enable low recovers
        mine = 1'b1;
        tick();
        ticks(MT - 1);
        check("mine_wait", 32'(state), 32'd3);
        tick();
        check("mine_to", 32'({state, fault, drive_brake, carriage_brake}), 32'b101_1_1_1);
        mine = 1'b0;
        tick();
        check("flt_sticky", 32'(fault), 32'd1);
        enable = 1'b0;
        tick();
        check("flt_off", 32'({state, fault}), 32'd0);

        // Saturating clearance counter
        enable = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            mine = 1'b1;
            tick();
            mine = 1'b0;
            ticks(SETTLE + 1);
        end
        check("mines_sat", 32'(mines_cleared), 32'd255);

        // Reset mid-sweep
        ticks(STEP);
        check("sweep4", 32'(state), 32'd2);
        ticks(2);
        rst_n = 1'b0;
        tick();
        check("rst_mid", 32'({state, drive_en, drive_brake, carriage_brake, fault, mines_cleared}),
              32'({3'd0, 4'b0110, 8'd0}));
        rst_n = 1'b1;
        tick();
        check("rst_resume", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
